// File: rtl/airi5c_sram_ahb_slave.sv
// airi5c_sram_ahb_slave: AHB-Lite slave in front of a single-port sync SRAM.
// Reads issue in the address phase; a read right behind a write waits one cycle.
module airi5c_sram_ahb_slave #(
    parameter int MEM_WORDS = 4096,
    parameter int ADDR_BITS = 12,
    parameter int READ_WAIT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hsel,
    input  logic [31:0]          haddr,
    input  logic                 hwrite,
    input  logic [2:0]           hsize,
    input  logic [1:0]           htrans,
    input  logic [31:0]          hwdata,
    output logic [31:0]          hrdata,
    output logic                 hready,
    output logic                 hresp,
    output logic                 sram_cs,
    output logic                 sram_we,
    output logic [3:0]           sram_be,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic [31:0]          sram_wdata,
    input  logic [31:0]          sram_rdata
);
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_RD_PEND, S_READ, S_ERR1, S_ERR2
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [3:0]           be_q, be_d;
    logic [2:0]           cnt_q, cnt_d;

    logic [ADDR_BITS-1:0] word_a;
    logic [3:0]           be_a;
    logic                 illegal;
    logic                 out_range;
    logic                 can_acc;
    logic                 unused_htrans;

    assign unused_htrans = htrans[0];
    assign word_a        = haddr[ADDR_BITS+1:2];
    assign out_range     = (haddr[31:ADDR_BITS+2] != '0)
                        || ({2'b00, haddr[31:2]} >= 32'(MEM_WORDS));

    always_comb begin
        illegal = out_range;
        be_a    = 4'hF;
        unique case (hsize)
            3'd0: be_a = 4'b0001 << haddr[1:0];
            3'd1: begin
                be_a    = 4'b0011 << {haddr[1], 1'b0};
                illegal = illegal | haddr[0];
            end
            3'd2: illegal = illegal | (haddr[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        be_d       = be_q;
        cnt_d      = cnt_q;
        hready     = 1'b1;
        hresp      = 1'b0;
        hrdata     = '0;
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_be    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        can_acc    = 1'b0;
        unique case (state_q)
            S_IDLE: can_acc = 1'b1;
            S_WRITE: begin
                sram_cs    = 1'b1;
                sram_we    = 1'b1;
                sram_be    = be_q;
                sram_addr  = addr_q;
                sram_wdata = hwdata;
                can_acc    = 1'b1;
                state_d    = S_IDLE;
            end
            S_RD_PEND: begin
                hready    = 1'b0;
                sram_cs   = 1'b1;
                sram_be   = be_q;
                sram_addr = addr_q;
                state_d   = S_READ;
                cnt_d     = 3'(READ_WAIT);
            end
            S_READ: begin
                if (cnt_q != 3'd0) begin
                    hready    = 1'b0;
                    sram_cs   = 1'b1;
                    sram_be   = be_q;
                    sram_addr = addr_q;
                    cnt_d     = cnt_q - 3'd1;
                end else begin
                    hrdata  = sram_rdata;
                    can_acc = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ERR1: begin
                hready  = 1'b0;
                hresp   = 1'b1;
                state_d = S_ERR2;
            end
            S_ERR2: begin
                hresp   = 1'b1;
                can_acc = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A read arriving during a write data phase must wait for the port.
        if (can_acc && hsel && htrans[1]) begin
            if (illegal) begin
                state_d = S_ERR1;
            end else begin
                addr_d = word_a;
                be_d   = be_a;
                if (hwrite) begin
                    state_d = S_WRITE;
                end else if (state_q == S_WRITE) begin
                    state_d = S_RD_PEND;
                end else begin
                    sram_cs   = 1'b1;
                    sram_we   = 1'b0;
                    sram_be   = be_a;
                    sram_addr = word_a;
                    state_d   = S_READ;
                    cnt_d     = 3'(READ_WAIT);
                end
            end
        end

        if (reset) begin
            hready     = 1'b1;
            hresp      = 1'b0;
            hrdata     = '0;
            sram_cs    = 1'b0;
            sram_we    = 1'b0;
            sram_be    = '0;
            sram_addr  = '0;
            sram_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_airi5c_sram_ahb_slave.sv
// Bench for airi5c_sram_ahb_slave: random AHB traffic against a byte-level
// memory model, plus directed reset, idle and slow-read sequences.
module tb_airi5c_sram_ahb_slave;
    localparam int MW = 4096;
    localparam int AB = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, hsel, hsel2, hwrite;
    logic [31:0]   haddr, hwdata;
    logic [2:0]    hsize;
    logic [1:0]    htrans;
    logic [31:0]   hrdata, hrdata2, rdat, rdat2, wdat, wdat2;
    logic          hready, hresp, hready2, hresp2;
    logic          cs, we, cs2, we2;
    logic [3:0]    be, be2;
    logic [AB-1:0] sa, sa2;

    airi5c_sram_ahb_slave #(.MEM_WORDS(MW), .ADDR_BITS(AB), .READ_WAIT(0)) u0 (
        .clk(clk), .reset(reset), .hsel(hsel), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .htrans(htrans), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .sram_cs(cs), .sram_we(we), .sram_be(be), .sram_addr(sa),
        .sram_wdata(wdat), .sram_rdata(rdat)
    );

    airi5c_sram_ahb_slave #(.MEM_WORDS(MW), .ADDR_BITS(AB), .READ_WAIT(2)) u2 (
        .clk(clk), .reset(reset), .hsel(hsel2), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .htrans(htrans), .hwdata(hwdata),
        .hrdata(hrdata2), .hready(hready2), .hresp(hresp2),
        .sram_cs(cs2), .sram_we(we2), .sram_be(be2), .sram_addr(sa2),
        .sram_wdata(wdat2), .sram_rdata(rdat2)
    );

    function automatic logic [31:0] pat(int w);
        return 32'h5A00_0000 ^ (32'(w) * 32'h0001_0203);
    endfunction

    // SRAM macros
    logic [31:0] sram [MW];
    always @(posedge clk) begin
        if (cs && we)
            for (int k = 0; k < 4; k++)
                if (be[k]) sram[sa][8*k +: 8] <= wdat[8*k +: 8];
        if (cs && !we) rdat <= sram[sa];
        if (cs2 && !we2) rdat2 <= pat(int'(sa2));
    end

    // Reference model
    logic [7:0] rmem [4*MW];

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
        logic [3:0]  be;
        int          word;
        int          waits;
    } exp_t;

    typedef struct {
        int          gap;
        logic [31:0] addr;
        bit          wr;
        logic [2:0]  size;
        logic [31:0] data;
    } tr_t;

    exp_t q[$];
    tr_t  stim[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, got, exp);
    endtask

    task automatic fail(string nm);
        n_checks++;
        $display("FAIL %s: bound expired", nm);
    endtask

    function automatic exp_t model(tr_t t, bit after_wr);
        exp_t e;
        int n, off;
        n      = 1 << ((t.size > 3'd2) ? 0 : int'(t.size));
        off    = int'(t.addr[1:0]);
        e.err  = (t.size > 3'd2) || ((int'(t.addr) & (n - 1)) != 0)
              || (t.addr >= 32'(4 * MW));
        e.rd   = !t.wr;
        e.word = int'(t.addr >> 2);
        e.be   = '0;
        e.data = t.data;
        e.waits = e.err ? 1 : (e.rd ? (after_wr ? 1 : 0) : 0);
        if (!e.err) begin
            for (int k = 0; k < 4; k++)
                if (k >= off && k < off + n) e.be[k] = 1'b1;
            for (int k = 0; k < 4; k++)
                if (t.wr && e.be[k]) rmem[4*e.word + k] = t.data[8*k +: 8];
            if (e.rd)
                e.data = {rmem[4*e.word+3], rmem[4*e.word+2],
                          rmem[4*e.word+1], rmem[4*e.word]};
        end
        return e;
    endfunction

    // Scoreboard monitor
    bit   mon_en = 0;
    bit   in_dp  = 0;
    int   waits  = 0;
    exp_t me;

    always @(negedge clk) begin
        if (!mon_en) begin
            in_dp = 0;
            waits = 0;
        end else begin
            if (in_dp) begin
                if (q.size() == 0) begin
                    fail("sb_empty");
                    in_dp = 0;
                end else if (!hready) begin
                    waits++;
                    check("wait_hresp", 32'(hresp), 32'(q[0].err));
                    if (q[0].err) check("err_cs", 32'(cs), 32'd0);
                    if (waits > 20) begin
                        fail("dp_timeout");
                        void'(q.pop_front());
                        in_dp = 0;
                        waits = 0;
                    end
                end else begin
                    me = q.pop_front();
                    check("hresp", 32'(hresp), 32'(me.err));
                    check("waits", 32'(waits), 32'(me.waits));
                    if (!me.err && me.rd) begin
                        check("hrdata", hrdata, me.data);
                    end else if (!me.err) begin
                        check("wr_cswe", {30'd0, cs, we}, 32'd3);
                        check("wr_be", 32'(be), 32'(me.be));
                        check("wr_addr", 32'(sa), 32'(me.word));
                        check("wr_data", wdat, me.data);
                        check("wr_hrdata", hrdata, 32'd0);
                    end
                    in_dp = 0;
                    waits = 0;
                end
            end
            if (hready && hsel && htrans[1]) in_dp = 1;
        end
    end

    task automatic add(int gap, logic [31:0] a, bit wr, logic [2:0] sz,
                       logic [31:0] d);
        tr_t t;
        t.gap = gap; t.addr = a; t.wr = wr; t.size = sz; t.data = d;
        stim.push_back(t);
    endtask

    task automatic run_stream();
        tr_t  cur;
        exp_t e;
        bit   a_act = 0, cur_err = 0, dp_wr = 0, dp_lw = 0, r;
        int   idx = 0, gap_left, cyc = 0;
        logic [31:0] dp_d = '0;
        gap_left = stim[0].gap;
        while ((idx < stim.size() || a_act || dp_wr) && cyc < 20000) begin
            if (!a_act && idx < stim.size()) begin
                if (gap_left > 0) begin
                    gap_left--;
                end else begin
                    cur = stim[idx];
                    idx++;
                    a_act = 1;
                    e = model(cur, dp_lw);
                    cur_err = e.err;
                    q.push_back(e);
                end
            end
            hsel   = 1'b1;
            htrans = a_act ? 2'b10 : 2'b00;
            haddr  = cur.addr;
            hwrite = cur.wr;
            hsize  = cur.size;
            hwdata = dp_wr ? dp_d : $urandom();
            @(negedge clk);
            r = hready;
            @(posedge clk);
            #1;
            cyc++;
            if (r) begin
                dp_wr = a_act && cur.wr && !cur_err;
                dp_d  = cur.data;
                dp_lw = dp_wr;
                if (a_act) begin
                    a_act = 0;
                    if (idx < stim.size()) gap_left = stim[idx].gap;
                end
            end
        end
        if (cyc >= 20000) fail("stream_budget");
        htrans = 2'b00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        tr_t  t;
        int   w, dp, lows, k, cyc;
        bit   r;
        logic [31:0] old;

        for (int i = 0; i < MW; i++) begin
            sram[i] = pat(i);
            {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]} = pat(i);
        end
        reset = 1; hsel = 0; hsel2 = 0; haddr = 0; hwrite = 0;
        hsize = 0; htrans = 0; hwdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hready", 32'(hready), 32'd1);
        check("rst_hresp", 32'(hresp), 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        check("rst_sram", {cs, we, be, 32'(sa), wdat}, 32'd0);
        @(posedge clk);
        #1 reset = 0;

        // directed
        add(1, 32'h10, 1, 3'd2, 32'hCAFE_BABE);
        add(0, 32'h10, 0, 3'd2, 32'h0);
        add(1, 32'h13, 1, 3'd0, 32'h5500_0000);
        add(0, 32'h12, 1, 3'd1, 32'hBEEF_0000);
        add(0, 32'h10, 0, 3'd2, 32'h0);
        add(1, 32'h0, 0, 3'd2, 32'h0);
        add(0, 32'h4, 0, 3'd2, 32'h0);
        add(0, 32'h8, 0, 3'd2, 32'h0);
        add(1, 32'h2, 0, 3'd2, 32'h0);
        add(1, 32'h4, 0, 3'd3, 32'h0);
        add(1, 32'(4 * MW), 0, 3'd2, 32'h0);
        // random
        for (int i = 0; i < 300; i++) begin
            t.gap  = ($urandom % 3 == 0) ? int'($urandom_range(1, 2)) : 0;
            t.wr   = 1'($urandom % 2);
            t.size = ($urandom % 16 == 0) ? 3'($urandom_range(3, 7))
                                          : 3'($urandom_range(0, 2));
            w = int'($urandom_range(0, 15));
            if ($urandom % 20 == 0) w = MW + int'($urandom_range(0, 100));
            k = int'($urandom_range(0, 3));
            if ($urandom % 4 != 0 && t.size <= 3'd2)
                k = k & ~((1 << int'(t.size)) - 1);
            t.addr = 32'(4 * w + k);
            t.data = $urandom();
            stim.push_back(t);
        end

        mon_en = 1;
        run_stream();
        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) fail("sb_drain");
        @(posedge clk);
        #1 mon_en = 0;

        // reset during a write data phase
        old = {rmem[163], rmem[162], rmem[161], rmem[160]};
        hsel = 1; htrans = 2'b10; haddr = 32'hA0; hwrite = 1; hsize = 3'd2;
        @(negedge clk);
        check("rw_accept", 32'(hready), 32'd1);
        @(posedge clk);
        #1 reset = 1; htrans = 2'b00; hwdata = 32'h0BAD_F00D;
        @(negedge clk);
        check("rw_we", {31'd0, we}, 32'd0);
        check("rw_cs", {31'd0, cs}, 32'd0);
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rw_hready", 32'(hready), 32'd1);
        check("rw_hresp", 32'(hresp), 32'd0);
        @(posedge clk);
        #1 htrans = 2'b10; hwrite = 0;
        @(negedge clk);
        check("rw_racc", 32'(hready), 32'd1);
        @(posedge clk);
        #1 htrans = 2'b00;
        @(negedge clk);
        check("rw_old", hrdata, old);
        check("rw_rdy", 32'(hready), 32'd1);

        // idle transfers with hsel high
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 hsel = 1; htrans = 2'($urandom_range(0, 1));
            haddr = $urandom(); hwrite = 1'($urandom % 2);
            @(negedge clk);
            check("idle_hready", 32'(hready), 32'd1);
            check("idle_hresp", 32'(hresp), 32'd0);
            check("idle_cs", 32'(cs), 32'd0);
        end

        // slow macro: back-to-back reads on READ_WAIT=2 instance
        @(posedge clk);
        #1 hsel = 0; hsel2 = 1; hwrite = 0; hsize = 3'd2;
        k = 0; dp = -1; lows = 0; cyc = 0;
        htrans = 2'b10; haddr = 32'h0;
        while ((k < 3 || dp >= 0) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            r = hready2;
            if (dp >= 0) begin
                if (!r) begin
                    lows++;
                end else begin
                    check("slow_lows", 32'(lows), 32'd2);
                    check("slow_data", hrdata2, pat(dp));
                    dp = -1;
                    lows = 0;
                end
            end
            if (r && k < 3) begin
                dp = k;
                k++;
            end
            @(posedge clk);
            #1;
            if (k < 3) begin
                htrans = 2'b10;
                haddr  = 32'(4 * k);
            end else begin
                htrans = 2'b00;
            end
        end
        if (cyc >= 100) fail("slow_budget");
        hsel2 = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
